processor_window_scheduler: RTL

//  Sequences the Haar-cascade processor over every window of a frame: walks (x,y,scale),

---
 rtl/processor_window_scheduler_pkg.sv | 35 +++
 rtl/processor_window_scheduler_walker.sv | 66 ++++++
 rtl/processor_window_scheduler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/processor_window_scheduler_pkg.sv
// Shared types for the Haar-cascade window scheduler: window origin record,
// loader and detector state encodings, and a small buffer-half helper.
package processor_window_scheduler_pkg;

    localparam int ROW_BITS_DEF   = 9;
    localparam int COL_BITS_DEF   = 9;
    localparam int SCALE_BITS_DEF = 4;
    localparam int STAGE_BITS_DEF = 5;

    typedef struct packed {
        logic [ROW_BITS_DEF-1:0]   x;
        logic [COL_BITS_DEF-1:0]   y;
        logic [SCALE_BITS_DEF-1:0] scale;
    } window_pos_t;

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_REQ  = 2'd1,
        L_FULL = 2'd2
    } load_state_t;

    typedef enum logic [2:0] {
        D_IDLE  = 3'd0,
        D_VAR   = 3'd1,
        D_WAITV = 3'd2,
        D_DET   = 3'd3,
        D_WAITD = 3'd4,
        D_RES   = 3'd5
    } det_state_t;

    function automatic logic other_half(input logic half);
        return ~half;
    endfunction

endpackage

// File: rtl/processor_window_scheduler_walker.sv
// Window origin walker: x fastest, then y, then scale. Wrap tests use one extra
// bit so a stride past the top of the coordinate range cannot alias back to 0.
module window_pos_walker #(
    parameter int ROW_BITS   = 9,
    parameter int COL_BITS   = 9,
    parameter int SCALE_BITS = 4,
    parameter int STEP       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [ROW_BITS-1:0]   max_x,
    input  logic [COL_BITS-1:0]   max_y,
    input  logic [SCALE_BITS-1:0] num_scales,
    output logic [ROW_BITS-1:0]   x,
    output logic [COL_BITS-1:0]   y,
    output logic [SCALE_BITS-1:0] scale,
    output logic                  last
);

    logic [ROW_BITS-1:0]   x_r;
    logic [COL_BITS-1:0]   y_r;
    logic [SCALE_BITS-1:0] scale_r;
    logic [ROW_BITS:0]     x_next_s;
    logic [COL_BITS:0]     y_next_s;
    logic                  x_wrap_s;
    logic                  y_wrap_s;
    logic                  scale_last_s;

    // Next-position arithmetic and wrap detection
    always_comb begin
        x_next_s     = {1'b0, x_r} + (ROW_BITS+1)'(STEP);
        y_next_s     = {1'b0, y_r} + (COL_BITS+1)'(STEP);
        x_wrap_s     = (x_next_s > {1'b0, max_x});
        y_wrap_s     = (y_next_s > {1'b0, max_y});
        scale_last_s = (scale_r == (num_scales - SCALE_BITS'(1)));
    end

    // Position counters
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            x_r     <= {ROW_BITS{1'b0}};
            y_r     <= {COL_BITS{1'b0}};
            scale_r <= {SCALE_BITS{1'b0}};
        end else if (advance) begin
            if (x_wrap_s) begin
                x_r <= {ROW_BITS{1'b0}};
                if (y_wrap_s) begin
                    y_r     <= {COL_BITS{1'b0}};
                    scale_r <= scale_r + SCALE_BITS'(1);
                end else begin
                    y_r <= y_next_s[COL_BITS-1:0];
                end
            end else begin
                x_r <= x_next_s[ROW_BITS-1:0];
            end
        end
    end

    assign x     = x_r;
    assign y     = y_r;
    assign scale = scale_r;
    assign last  = x_wrap_s & y_wrap_s & scale_last_s;

endmodule

// File: rtl/processor_window_scheduler.sv
// Frame-level sequencer for the cascade processor: loads the idle cache half
// while the other half runs variance + detection, and returns one result per window.
module processor_window_scheduler
    import processor_window_scheduler_pkg::*;
#(
    parameter int ROW_BITS   = 9,
    parameter int COL_BITS   = 9,
    parameter int SCALE_BITS = 4,
    parameter int STAGE_BITS = 5,
    parameter int STEP       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [ROW_BITS-1:0]   cfg_max_x,
    input  logic [COL_BITS-1:0]   cfg_max_y,
    input  logic [SCALE_BITS-1:0] cfg_num_scales,
    input  logic [STAGE_BITS-1:0] cfg_num_stages,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  load_req,
    output logic                  load_buf,
    output logic [ROW_BITS-1:0]   load_x,
    output logic [COL_BITS-1:0]   load_y,
    output logic [SCALE_BITS-1:0] load_scale,
    input  logic                  load_ack,
    output logic                  var_start,
    input  logic                  var_ready,
    output logic                  det_start,
    output logic                  det_dbl_buf,
    output logic [STAGE_BITS-1:0] det_num_stages,
    input  logic                  det_done,
    input  logic                  det_passfail,
    output logic                  res_valid,
    output logic                  res_passfail,
    output logic [ROW_BITS-1:0]   res_x,
    output logic [COL_BITS-1:0]   res_y,
    output logic [SCALE_BITS-1:0] res_scale,
    input  logic                  res_taken
);

    load_state_t l_state_r, l_next_s;
    det_state_t  d_state_r, d_next_s;

    logic                  busy_r, frame_done_r, buf_ptr_r, all_loaded_r;
    logic                  det_buf_r, det_last_r;
    logic [ROW_BITS-1:0]   max_x_r, det_x_r, res_x_r;
    logic [COL_BITS-1:0]   max_y_r, det_y_r, res_y_r;
    logic [SCALE_BITS-1:0] num_scales_r, det_scale_r, res_scale_r;
    logic [STAGE_BITS-1:0] num_stages_r;
    logic                  res_valid_r, res_passfail_r;

    logic                  accept_s, claim_s, last_taken_s;
    logic [ROW_BITS-1:0]   pos_x_s;
    logic [COL_BITS-1:0]   pos_y_s;
    logic [SCALE_BITS-1:0] pos_scale_s;
    logic                  pos_last_s;

    assign accept_s     = frame_start & ~busy_r;
    // The detector takes the freshly loaded half only when it is idle; that
    // hand-over is also what frees the loader for the other half.
    assign claim_s      = busy_r & (l_state_r == L_FULL) & (d_state_r == D_IDLE);
    assign last_taken_s = (d_state_r == D_RES) & res_taken & det_last_r;

    window_pos_walker #(
        .ROW_BITS   (ROW_BITS),
        .COL_BITS   (COL_BITS),
        .SCALE_BITS (SCALE_BITS),
        .STEP       (STEP)
    ) u_walker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept_s),
        .advance    (claim_s & ~pos_last_s),
        .max_x      (max_x_r),
        .max_y      (max_y_r),
        .num_scales (num_scales_r),
        .x          (pos_x_s),
        .y          (pos_y_s),
        .scale      (pos_scale_s),
        .last       (pos_last_s)
    );

    // Frame acceptance, configuration latch and completion pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            max_x_r      <= {ROW_BITS{1'b0}};
            max_y_r      <= {COL_BITS{1'b0}};
            num_scales_r <= {SCALE_BITS{1'b0}};
            num_stages_r <= {STAGE_BITS{1'b0}};
        end else begin
            frame_done_r <= 1'b0;
            if (accept_s) begin
                max_x_r      <= cfg_max_x;
                max_y_r      <= cfg_max_y;
                num_scales_r <= cfg_num_scales;
                num_stages_r <= cfg_num_stages;
                if (cfg_num_scales == {SCALE_BITS{1'b0}}) begin
                    frame_done_r <= 1'b1;
                end else begin
                    busy_r <= 1'b1;
                end
            end else if (last_taken_s) begin
                busy_r       <= 1'b0;
                frame_done_r <= 1'b1;
            end
        end
    end

    // FSM state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            l_state_r <= L_IDLE;
            d_state_r <= D_IDLE;
        end else begin
            l_state_r <= l_next_s;
            d_state_r <= d_next_s;
        end
    end

    // Loader next-state
    always_comb begin
        l_next_s = l_state_r;
        case (l_state_r)
            L_IDLE: begin
                if (busy_r && !all_loaded_r) l_next_s = L_REQ;
                else                         l_next_s = L_IDLE;
            end
            L_REQ: begin
                if (load_ack) l_next_s = L_FULL;
                else          l_next_s = L_REQ;
            end
            L_FULL: begin
                if (claim_s) l_next_s = pos_last_s ? L_IDLE : L_REQ;
                else         l_next_s = L_FULL;
            end
            default: l_next_s = L_IDLE;
        endcase
    end

    // Detector next-state; start pulses last exactly one cycle in D_VAR / D_DET
    always_comb begin
        d_next_s = d_state_r;
        case (d_state_r)
            D_IDLE: begin
                if (claim_s) d_next_s = D_VAR;
                else         d_next_s = D_IDLE;
            end
            D_VAR:   d_next_s = D_WAITV;
            D_WAITV: begin
                if (var_ready) d_next_s = D_DET;
                else           d_next_s = D_WAITV;
            end
            D_DET:   d_next_s = D_WAITD;
            D_WAITD: begin
                if (det_done) d_next_s = D_RES;
                else          d_next_s = D_WAITD;
            end
            D_RES: begin
                if (res_taken) d_next_s = D_IDLE;
                else           d_next_s = D_RES;
            end
            default: d_next_s = D_IDLE;
        endcase
    end

    // Buffer pointer, claimed-window record and result holding registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_ptr_r      <= 1'b0;
            all_loaded_r   <= 1'b0;
            det_buf_r      <= 1'b0;
            det_last_r     <= 1'b0;
            det_x_r        <= {ROW_BITS{1'b0}};
            det_y_r        <= {COL_BITS{1'b0}};
            det_scale_r    <= {SCALE_BITS{1'b0}};
            res_valid_r    <= 1'b0;
            res_passfail_r <= 1'b0;
            res_x_r        <= {ROW_BITS{1'b0}};
            res_y_r        <= {COL_BITS{1'b0}};
            res_scale_r    <= {SCALE_BITS{1'b0}};
        end else begin
            if (accept_s) begin
                buf_ptr_r    <= 1'b0;
                all_loaded_r <= 1'b0;
            end else if (claim_s) begin
                buf_ptr_r    <= other_half(buf_ptr_r);
                all_loaded_r <= pos_last_s;
                det_buf_r    <= buf_ptr_r;
                det_last_r   <= pos_last_s;
                det_x_r      <= pos_x_s;
                det_y_r      <= pos_y_s;
                det_scale_r  <= pos_scale_s;
            end
            if (d_state_r == D_WAITD && det_done) begin
                res_valid_r    <= 1'b1;
                res_passfail_r <= det_passfail;
                res_x_r        <= det_x_r;
                res_y_r        <= det_y_r;
                res_scale_r    <= det_scale_r;
            end else if (d_state_r == D_RES && res_taken) begin
                res_valid_r <= 1'b0;
            end
        end
    end

    assign busy           = busy_r;
    assign frame_done     = frame_done_r;
    assign load_req       = (l_state_r == L_REQ);
    assign load_buf       = buf_ptr_r;
    assign load_x         = pos_x_s;
    assign load_y         = pos_y_s;
    assign load_scale     = pos_scale_s;
    assign var_start      = (d_state_r == D_VAR);
    assign det_start      = (d_state_r == D_DET);
    assign det_dbl_buf    = det_buf_r;
    assign det_num_stages = num_stages_r;
    assign res_valid      = res_valid_r;
    assign res_passfail   = res_passfail_r;
    assign res_x          = res_x_r;
    assign res_y          = res_y_r;
    assign res_scale      = res_scale_r;

endmodule
